// File: rtl/memc_deskew_if.sv
// Bus bundle between the systolic array result lanes, the host read port and memc_deskew.
// Skewed lanes, capture control, host read address/data and status flags.
interface memc_deskew_if #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
);
  // No valid/ready pair here: en is a level qualifier (a lane sample is consumed
  // on every rising edge with en=1 in CAPTURE and nothing moves while en=0),
  // and clr is a one-cycle pulse that restarts a capture and overrides en.
  logic                          en;
  logic                          clr;
  logic [DIM-1:0][BITS_C-1:0]    Cin;
  logic [$clog2(DIM)-1:0]        Crow;
  logic [DIM-1:0][BITS_C-1:0]    Cout;
  logic                          busy;
  logic                          done;

  modport master (output en, clr, Cin, Crow, input Cout, busy, done);
  modport slave  (input en, clr, Cin, Crow, output Cout, busy, done);
endinterface

// File: rtl/memc_deskew.sv
// Removes the diagonal skew from the systolic array result stream with per-lane delay
// lines, stores the aligned DIM x DIM matrix and serves registered row reads to the host.
module memc_deskew #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8,
  localparam int AW    = $clog2(DIM),
  localparam int CW    = $clog2(2*DIM)
) (
  input  logic              clk,
  input  logic              rst,
  memc_deskew_if.slave      ifc,
  output logic [1:0]        dbg_state,
  output logic [CW-1:0]     dbg_cyc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                      state, state_nxt;
  logic [CW-1:0]               cyc;
  logic                        shift, write, last;
  logic [AW-1:0]               wr_idx;
  logic [DIM-1:0][BITS_C-1:0]  aligned;
  logic [DIM-1:0][BITS_C-1:0]  buffer [DIM];

  // clr overrides en, so a restart cycle never samples or writes.
  assign shift  = (state == CAPTURE) && ifc.en && !ifc.clr;
  assign write  = shift && (cyc >= CW'(DIM-1));
  assign last   = write && (cyc == CW'(2*DIM-2));
  assign wr_idx = AW'(cyc - CW'(DIM-1));

  assign dbg_state = state;
  assign dbg_cyc   = cyc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ifc.clr) begin
      state_nxt = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (last) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ifc.busy = (state == CAPTURE);
    ifc.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || ifc.clr) cyc <= '0;
    else if (shift)     cyc <= cyc + CW'(1);
  end

  // Lane i waits DIM-1-i enabled cycles so every element of a row lines up with lane DIM-1.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    localparam int D = DIM - 1 - i;
    if (D == 0) begin : g_wire
      assign aligned[i] = ifc.Cin[i];
    end else begin : g_dly
      logic [BITS_C-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (rst || ifc.clr) begin
          for (int k = 0; k < D; k++) sr[k] <= '0;
        end else if (shift) begin
          sr[0] <= ifc.Cin[i];
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      assign aligned[i] = sr[D-1];
    end
  end

  // Same-cycle read of the row being written returns the previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) buffer[r] <= '0;
      ifc.Cout <= '0;
    end else begin
      if (write) buffer[wr_idx] <= aligned;
      ifc.Cout <= buffer[ifc.Crow];
    end
  end

endmodule

// File: tb/tb_memc_deskew.sv
// Self-checking bench for memc_deskew: directed and randomized captures checked against
// a matrix-level reference model of the stored buffer and the done timing.
module tb_memc_deskew;
  localparam int BITS_C = 16;
  localparam int DIM    = 4;
  localparam int NCYC   = 2*DIM - 1;
  localparam int W      = DIM*BITS_C;
  localparam int CW     = $clog2(2*DIM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_cyc;

  memc_deskew_if #(.BITS_C(BITS_C), .DIM(DIM)) ifc ();

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifc       (ifc),
    .dbg_state (dbg_state),
    .dbg_cyc   (dbg_cyc)
  );

  // ---------------- reference model / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [BITS_C-1:0] mat [DIM][DIM];   // matrix being streamed
  logic [BITS_C-1:0] mem [DIM][DIM];   // expected buffer contents
  logic [W-1:0]      exp_q[$];
  bit                m_done = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_row(input int r);
    logic [W-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*BITS_C +: BITS_C] = mem[r][i];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes(input int k);
    for (int i = 0; i < DIM; i++) begin
      if (k - i >= 0 && k - i < DIM) ifc.Cin[i] = mat[k-i][i];
      else                           ifc.Cin[i] = '0;
    end
  endtask

  task automatic do_clr(input bit with_en);
    ifc.clr = 1'b1;
    ifc.en  = with_en;
    for (int i = 0; i < DIM; i++) ifc.Cin[i] = BITS_C'($urandom_range(1, 65535));
    step();
    ifc.clr = 1'b0;
    ifc.en  = 1'b0;
    m_done  = 1'b0;
    check("clr_cyc",  dbg_cyc,  0);
    check("clr_busy", ifc.busy, 1);
    check("clr_done", ifc.done, 0);
  endtask

  // stall_mode: 0 = en always, 1 = en low every third cycle, 2 = random en
  task automatic run_capture(input int stall_mode, input int abort_at, output int cycles);
    int  k = 0;
    int  c = 0;
    bit  e;
    while (k < NCYC && k != abort_at) begin
      case (stall_mode)
        0:       e = 1'b1;
        1:       e = (c % 3 != 2);
        default: e = ($urandom_range(0, 3) != 0);
      endcase
      ifc.en = e;
      if (e) drive_lanes(k);
      step();
      c++;
      if (e) begin
        if (k >= DIM-1)
          for (int i = 0; i < DIM; i++) mem[k-DIM+1][i] = mat[k-DIM+1][i];
        k++;
      end
      check("done_flag", ifc.done, (k == NCYC));
      check("busy_flag", ifc.busy, (k != NCYC));
      if (c > 200) begin
        total++; bad++;
        $error("FAIL capture_timeout observed=%0d cycles expected<=200", c);
        break;
      end
    end
    ifc.en = 1'b0;
    if (k == NCYC) m_done = 1'b1;
    cycles = c;
  endtask

  task automatic read_row(input int r);
    ifc.Crow = r[$clog2(DIM)-1:0];
    exp_q.push_back(pack_row(r));
    step();
    check($sformatf("cout_row%0d", r), ifc.Cout, exp_q.pop_front());
    check("done_hold", ifc.done, m_done);
  endtask

  task automatic read_all();
    for (int r = 0; r < DIM; r++) read_row(r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc_used;
    ifc.en = 1'b0; ifc.clr = 1'b0; ifc.Crow = '0; ifc.Cin = '0;
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mem[r][i] = '0;

    // reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_state", dbg_state, 0);
    check("rst_busy",  ifc.busy,  0);
    check("rst_done",  ifc.done,  0);
    check("rst_cout",  ifc.Cout,  0);
    read_all();

    // basic capture, C[r][i] = 16r+i
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = BITS_C'(16*r + i);
    do_clr(1'b0);
    run_capture(0, -1, cyc_used);
    check("basic_len", cyc_used, NCYC);
    read_all();
    ifc.Crow = 2;
    step();
    check("row2_const", ifc.Cout, {16'd35, 16'd34, 16'd33, 16'd32});

    // negative values
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = BITS_C'(-((r+1)*(i+1)));
    do_clr(1'b0);
    run_capture(0, -1, cyc_used);
    read_all();
    ifc.Crow = 3;
    step();
    check("neg_c33", ifc.Cout[3], 16'hFFF0);

    // stall every third cycle, basic matrix again; clr issued together with en
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = BITS_C'(16*r + i);
    do_clr(1'b1);
    run_capture(1, -1, cyc_used);
    check("stall_len", cyc_used, NCYC + (NCYC-1)/2);
    read_all();

    // restart mid-capture, buffer must keep its contents across clr
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = BITS_C'($urandom);
    do_clr(1'b0);
    run_capture(0, 4, cyc_used);
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = 16'h0055;
    do_clr(1'b1);
    read_all();
    run_capture(0, -1, cyc_used);
    check("restart_len", cyc_used, NCYC);
    read_all();

    // randomized matrices with random stalls and random-order reads
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = BITS_C'($urandom);
      do_clr(1'($urandom_range(0, 1)));
      run_capture(2, -1, cyc_used);
      for (int n = 0; n < 6; n++) read_row($urandom_range(0, DIM-1));
    end

    // reset in the middle of a capture
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mat[r][i] = BITS_C'($urandom);
    do_clr(1'b0);
    run_capture(0, 5, cyc_used);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < DIM; r++) for (int i = 0; i < DIM; i++) mem[r][i] = '0;
    m_done = 1'b0;
    check("mrst_state", dbg_state, 0);
    check("mrst_busy",  ifc.busy,  0);
    check("mrst_done",  ifc.done,  0);
    ifc.en = 1'b1;
    step(); step();
    ifc.en = 1'b0;
    check("idle_en_state", dbg_state, 0);
    check("idle_en_cyc",   dbg_cyc,   0);
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memc_deskew.md
Name: memc_deskew

Overview:
- Output-side counterpart of the A-matrix skewing memory.
- Captures the diagonally skewed result stream leaving the systolic array and removes the skew with per-lane delay lines.
- Stores the aligned DIM x DIM result matrix and lets the host read it row by row.
- Sits between the systolic array's C outputs and the host/AFU read path.

Parameters:
- BITS_C, 16, width of each signed result element.
- DIM, 8, array dimension: number of lanes, number of rows stored, and stored row width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  advance enable; pipeline and cycle counter move only when en=1.
- clr  input  1  start a new capture; pulse.
- Cin  input  DIM x BITS_C signed  skewed result lanes from the array; lane i carries column i.
- Crow  input  $clog2(DIM)  row address for host read.
- Cout  output  DIM x BITS_C signed  registered read data, buffer row Crow.
- busy  output  1  high while in CAPTURE.
- done  output  1  high once a full matrix is captured; held until clr or rst.

Behaviour:
- Reset: on rst=1 at a clock edge, clear all of the following to 0:
  - state to IDLE, cyc
  - every delay-line register and every buffer entry
  - Cout, busy, done
- rst has priority over everything, including mid-capture; the partial capture is discarded.
- Input timing: element C[r][i] appears on Cin[i] at enabled capture cycle r+i, where cycle 0 is the first en=1 cycle after clr.
- De-skew: lane i passes through DIM-1-i register stages, advanced only on en=1 in CAPTURE. Lane DIM-1 is a direct wire. After the delays, all elements of row r are aligned at enabled cycle r+DIM-1.
- FSM states are IDLE, CAPTURE and DONE.
  - IDLE: busy=0, done=0. clr moves to CAPTURE with cyc=0.
  - CAPTURE: busy=1. On each en=1 cycle, shift the delay lines and increment cyc. When cyc >= DIM-1, write the aligned row to buffer[cyc-(DIM-1)]. The write at cyc = 2*DIM-2 is the last one; it moves to DONE.
  - DONE: busy=0, done=1. Delay lines are frozen. clr moves to CAPTURE.
- clr in any state (including mid-CAPTURE) does the following:
  - sets cyc=0, zeroes the delay lines, clears done and enters CAPTURE;
  - leaves buffer contents untouched.
- clr and en high in the same cycle: clr wins; no shift, no sampling, no write that cycle.
- en=0 in CAPTURE: full stall; no register changes.
- Total capture time is 2*DIM-1 enabled cycles after clr. done rises on the edge that performs the final write, so it is visible the following cycle.
- Read path:
  - Cout <= buffer[Crow] every clock, independent of en and state; 1-cycle latency.
  - A read of the row being written in the same cycle returns the old contents.
- Width and arithmetic: values pass through unmodified; no arithmetic and no sign change.

Test Plan:
- Reset check, DIM=4, BITS_C=16: assert rst for 2 cycles -> Cout=0 for every Crow, busy=0, done=0.
- Basic capture: drive C[r][i]=16*r+i skewed (lane i delayed i cycles, zeros elsewhere), en=1 throughout, after clr -> done=1 exactly 7 enabled cycles after clr; reading Crow=2 returns {32,33,34,35} one cycle after address.
- Stall: same stimulus with en=0 on every third cycle (Cin held during stalls) -> identical buffer contents; done delayed by the stall count.
- Negative values: C[r][i]=-(r+1)*(i+1), e.g. C[3][3]=-16 (0xFFF0) -> read back bit-exact, sign preserved.
- Restart: clr asserted at enabled cycle 4 of a capture, then a fresh matrix of all 0x0055 -> done after 7 more enabled cycles; all rows read 0x0055.
- Mid-operation reset and priority: rst during CAPTURE -> state IDLE and buffer zero next cycle; clr+en in same cycle -> cyc stays 0 and no shift occurs.
